sakebi_frame_writer: RTL

Write-side producer for the async FIFO: accepts a length-prefixed message from the write-clock-domain source and emits a self-delimiting frame (length byte, payload bytes, XOR checksum byte) into the FIFO write port. The frame is written one word per accepted beat and stalls while the FIFO reports not-ready. The block sits between the packet source and the FIFO on the i_wr_clk side; the read-side deframer consumes the same format.

---
 rtl/sakebi_frame_pkg.sv | 21 ++
 rtl/sakebi_frame_writer_if.sv | 29 ++
 rtl/sakebi_xor_csum.sv | 29 ++
 rtl/sakebi_frame_writer.sv | 99 +++++++++
 4 files changed

// File: rtl/sakebi_frame_pkg.sv
// Shared definitions for the sakebi frame writer and the read-side deframer:
// state encoding, frame overhead and the XOR checksum step.
package sakebi_frame_pkg;

  localparam int FRAME_DW       = 8;
  localparam int FRAME_OVERHEAD = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } frame_state_e;

  // One step of the running checksum: length word and payload words XORed, no carry.
  function automatic logic [FRAME_DW-1:0] csum_step(input logic [FRAME_DW-1:0] acc,
                                                    input logic [FRAME_DW-1:0] word);
    return acc ^ word;
  endfunction

endpackage

// File: rtl/sakebi_frame_writer_if.sv
// Source/control and FIFO-write signals of the frame writer, bundled for port hookup.
interface sakebi_frame_writer_if #(
  parameter int DATA_WIDTH = 8
);
  // Handshakes: a payload word moves when i_src_valid & o_src_ready are both high on a
  // rising edge; a FIFO word is written when o_fifo_wr_en is high, which is only ever
  // asserted while i_fifo_wr_ready is high. i_start is a single-cycle request.
  logic                  i_start;
  logic [DATA_WIDTH-1:0] i_len;
  logic                  o_busy;
  logic                  i_src_valid;
  logic                  o_src_ready;
  logic [DATA_WIDTH-1:0] i_src_data;
  logic                  i_fifo_wr_ready;
  logic                  o_fifo_wr_en;
  logic [DATA_WIDTH-1:0] o_fifo_wr_data;
  logic                  o_done;

  modport master (
    output i_start, i_len, i_src_valid, i_src_data, i_fifo_wr_ready,
    input  o_busy, o_src_ready, o_fifo_wr_en, o_fifo_wr_data, o_done
  );

  modport slave (
    input  i_start, i_len, i_src_valid, i_src_data, i_fifo_wr_ready,
    output o_busy, o_src_ready, o_fifo_wr_en, o_fifo_wr_data, o_done
  );

endinterface

// File: rtl/sakebi_xor_csum.sv
// Registered XOR accumulator; clear has priority over enable. Also used by the deframer.
module sakebi_xor_csum
  import sakebi_frame_pkg::*;
#(
  parameter int W = FRAME_DW
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_csum
);

  logic [W-1:0] r_acc;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_csum = r_acc;

endmodule

// File: rtl/sakebi_frame_writer.sv
// Turns a length-prefixed message into a length/payload/checksum frame written one
// word per accepted beat into the async FIFO write port.
module sakebi_frame_writer
  import sakebi_frame_pkg::*;
#(
  parameter int DATA_WIDTH = FRAME_DW
) (
  input  logic                  i_wr_clk,
  input  logic                  i_wr_rstn,
  sakebi_frame_writer_if.slave  bus,
  output frame_state_e          o_state
);

  frame_state_e          r_state;
  logic [DATA_WIDTH-1:0] r_len;
  logic [DATA_WIDTH-1:0] r_remain;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] w_csum;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic                  w_wr_en;
  logic                  w_start;
  logic                  w_csum_en;

  // Gated purely by the live ready input, so a full FIFO never receives a write.
  assign w_wr_en = bus.i_fifo_wr_ready &
                   ((r_state == ST_LEN) | (r_state == ST_CSUM) |
                    ((r_state == ST_DATA) & bus.i_src_valid));

  assign w_start   = (r_state == ST_IDLE) & bus.i_start;
  assign w_csum_en = w_wr_en & (r_state != ST_CSUM);

  always_comb begin
    w_wr_data = '0;
    case (r_state)
      ST_LEN:  w_wr_data = r_len;
      ST_DATA: w_wr_data = bus.i_src_data;
      ST_CSUM: w_wr_data = w_csum;
      default: w_wr_data = '0;
    endcase
  end

  // The accumulator is cleared on start, so the LEN write leaves it equal to r_len.
  sakebi_xor_csum #(.W(DATA_WIDTH)) u_csum (
    .i_clk  (i_wr_clk),
    .i_rstn (i_wr_rstn),
    .i_clr  (w_start),
    .i_en   (w_csum_en),
    .i_data (w_wr_data),
    .o_csum (w_csum)
  );

  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      r_state  <= ST_IDLE;
      r_len    <= '0;
      r_remain <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_len    <= bus.i_len;
            r_remain <= bus.i_len;
            r_state  <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (w_wr_en) begin
            r_state <= (r_len != '0) ? ST_DATA : ST_CSUM;
          end
        end
        ST_DATA: begin
          if (w_wr_en) begin
            r_remain <= r_remain - DATA_WIDTH'(1);
            if (r_remain == DATA_WIDTH'(1)) begin
              r_state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (w_wr_en) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_busy         = (r_state != ST_IDLE);
  assign bus.o_src_ready    = (r_state == ST_DATA) & bus.i_fifo_wr_ready;
  assign bus.o_fifo_wr_en   = w_wr_en;
  assign bus.o_fifo_wr_data = w_wr_data;
  assign bus.o_done         = r_done;
  assign o_state            = r_state;

endmodule
